// File: rtl/reg_file_sb_if.sv
// ---------------------------------------------------------------------------
// reg_file_sb_if
//   Bundle of the register-file operand, writeback, issue and status signals.
//   master : decode/hazard side (drives addresses, writeback, issue, flush)
//   slave  : the register file itself
//
//   RR1, RR2   read addresses            RD1, RD2   read data (combinational)
//   busy1/2    pending-write flags       WR, WD     writeback address/data
//   regwrite   writeback enable          iss_valid  issue strobe
//   iss_rd     issue destination         flush      clear all pending bits
//   pend_cnt   registered count of pending registers
// ---------------------------------------------------------------------------
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] RR1;
    logic [ADDR_W-1:0] RR2;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic              busy1;
    logic              busy2;
    logic [ADDR_W-1:0] WR;
    logic [DATA_W-1:0] WD;
    logic              regwrite;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic              flush;
    logic [ADDR_W:0]   pend_cnt;

    modport master (
        output RR1, RR2, WR, WD, regwrite, iss_valid, iss_rd, flush,
        input  RD1, RD2, busy1, busy2, pend_cnt
    );

    modport slave (
        input  RR1, RR2, WR, WD, regwrite, iss_valid, iss_rd, flush,
        output RD1, RD2, busy1, busy2, pend_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//   CPU register file with same-cycle write-through bypass and a per-register
//   pending (scoreboard) bit, so hazard logic can stall on busy1/busy2.
//
//   clk   rising-edge clock
//   rst   synchronous active-high reset (clears data, pending bits, count)
//   bus   reg_file_sb_if.slave: two combinational read ports with busy flags,
//         one writeback port, one issue port, flush, registered pend_cnt.
//
//   ZERO_R0=1 makes register 0 a hard zero: reads 0, ignores writes and can
//   never become pending.
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter bit ZERO_R0 = 1'b1
) (
    input logic          clk,
    input logic          rst,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  pending_reg;
    logic [DEPTH-1:0]  pending_next;
    logic [ADDR_W:0]   pend_cnt_reg;
    logic [ADDR_W:0]   pend_cnt_next;
    logic              wr_legal;

    // A write to the hard-zero register is dropped everywhere: no data update,
    // no bypass, no pending clear.
    assign wr_legal = bus.regwrite && ((bus.WR != '0) || !ZERO_R0);

    // Pending next state: an issue always leaves its register pending (even
    // alongside flush or a writeback to the same register, since a newer
    // producer now owns it); otherwise flush or a writeback clears it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
        if (ZERO_R0 && (gi == 0)) begin : g_r0
            assign pending_next[gi] = 1'b0;
        end else begin : g_rn
            logic set_hit;
            logic clr_hit;
            assign set_hit = bus.iss_valid && (bus.iss_rd == ADDR_W'(gi));
            assign clr_hit = wr_legal && (bus.WR == ADDR_W'(gi));
            assign pending_next[gi] = set_hit | (~bus.flush & ~clr_hit & pending_reg[gi]);
        end
    end

    // Count is taken from the next state so the registered value always
    // matches the pending array right after each edge.
    always_comb begin
        pend_cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt_next = pend_cnt_next + {{ADDR_W{1'b0}}, pending_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg  <= '0;
            pend_cnt_reg <= '0;
        end else begin
            pending_reg  <= pending_next;
            pend_cnt_reg <= pend_cnt_next;
        end
    end

    // Data array needs a full clear on reset, so it maps to fabric registers
    // rather than a RAM primitive.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_legal) begin
            regs_reg[bus.WR] <= bus.WD;
        end
    end

    // Read ports: hard zero, then same-cycle bypass, then stored value.
    // A writeback hitting the read address also releases busy this cycle,
    // matching the data the reader sees through the bypass.
    logic [ADDR_W-1:0] rr_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic [1:0]        rd_busy;

    assign rr_addr[0] = bus.RR1;
    assign rr_addr[1] = bus.RR2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic zero_hit;
        logic byp_hit;
        assign zero_hit    = ZERO_R0 && (rr_addr[gi] == '0);
        assign byp_hit     = wr_legal && (bus.WR == rr_addr[gi]);
        assign rd_data[gi] = zero_hit ? '0 : (byp_hit ? bus.WD : regs_reg[rr_addr[gi]]);
        assign rd_busy[gi] = ~zero_hit & pending_reg[rr_addr[gi]] & ~byp_hit;
    end

    assign bus.RD1      = rd_data[0];
    assign bus.RD2      = rd_data[1];
    assign bus.busy1    = rd_busy[0];
    assign bus.busy2    = rd_busy[1];
    assign bus.pend_cnt = pend_cnt_reg;
endmodule
